// File: rtl/riscv_lsu_if.sv
// Load/store unit bus bundle.
// Carries the M-stage request side and the memory side.
interface riscv_lsu_if #(
  parameter int XLEN = 32
) ();
  localparam int NB = XLEN / 8;

  logic            req_valid;
  logic            req_write;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] rdata;
  logic            fault;

  logic            mem_req;
  logic            mem_we;
  logic [NB-1:0]   mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, funct3,
    input  addr, wdata, mem_ack, mem_rdata,
    output stall, done, rdata, fault,
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, funct3,
    output addr, wdata, mem_ack, mem_rdata,
    input  stall, done, rdata, fault,
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: M-stage access sequencer.
// Aligns stores onto byte lanes, extends loads, stalls pipeline.
module riscv_lsu #(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8
) (
  input logic clk,
  input logic reset,
  riscv_lsu_if.slave bus
);
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [NB-1:0]   mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            legal;
  logic [NB-1:0]   be_mask;
  logic [OFFW-1:0] al_mask;
  logic [OFFW-1:0] off;
  logic            bad;
  logic            accept;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ext;

  assign off = bus.addr[OFFW-1:0];

  // Decode access width into lane mask and alignment mask.
  always_comb begin
    legal   = 1'b1;
    be_mask = '0;
    al_mask = '0;
    unique case (bus.funct3)
      3'b000, 3'b100: begin
        be_mask = NB'(1);
        al_mask = '0;
      end
      3'b001, 3'b101: begin
        be_mask = NB'(3);
        al_mask = OFFW'(1);
      end
      3'b010: begin
        be_mask = NB'(15);
        al_mask = OFFW'(3);
      end
      3'b110: begin
        legal   = (XLEN == 64);
        be_mask = NB'(15);
        al_mask = OFFW'(3);
      end
      3'b011: begin
        legal   = (XLEN == 64);
        be_mask = '1;
        al_mask = OFFW'(7);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  assign bad    = !legal | (|(off & al_mask));
  assign accept = (state_q == IDLE) & bus.req_valid & !bad;

  // Right-align the read word and extend from the access width.
  always_comb begin
    sh  = bus.mem_rdata >> {off_q, 3'b000};
    ext = sh;
    unique case (f3_q)
      3'b000:  ext = XLEN'($signed(sh << (XLEN - 8)) >>> (XLEN - 8));
      3'b100:  ext = (sh << (XLEN - 8)) >> (XLEN - 8);
      3'b001:  ext = XLEN'($signed(sh << (XLEN - 16)) >>> (XLEN - 16));
      3'b101:  ext = (sh << (XLEN - 16)) >> (XLEN - 16);
      3'b010:  ext = XLEN'($signed(sh << (XLEN - 32)) >>> (XLEN - 32));
      3'b110:  ext = (sh << (XLEN - 32)) >> (XLEN - 32);
      default: ext = sh;
    endcase
  end

  // Next-state and registered bus outputs.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    f3_d        = f3_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = BUSY;
          off_d       = off;
          f3_d        = bus.funct3;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.req_write;
          mem_be_d    = be_mask << off;
          mem_addr_d  = {bus.addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          mem_wdata_d = bus.wdata << {off, 3'b000};
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) rdata_d = ext;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over a same-cycle mem_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      off_q       <= '0;
      f3_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.fault     = (state_q == IDLE) & bus.req_valid & bad;
  assign bus.stall     = accept | (state_q == BUSY);
  assign bus.done      = (state_q == DONE);
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu at XLEN=32 and XLEN=64.
// Directed and random accesses against an arithmetic reference.
module tb_riscv_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  bit          use64 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;

  int nvec = 0;
  int nerr = 0;
  logic [63:0] exp_rd32 = '0;
  logic [63:0] exp_rd64 = '0;

  always #5 clk = ~clk;

  riscv_lsu_if #(.XLEN(32)) i32 ();
  riscv_lsu_if #(.XLEN(64)) i64 ();

  riscv_lsu #(.XLEN(32)) u32 (.clk(clk), .reset(reset), .bus(i32));
  riscv_lsu #(.XLEN(64)) u64 (.clk(clk), .reset(reset), .bus(i64));

  assign i32.req_valid = req_valid & !use64;
  assign i32.req_write = req_write;
  assign i32.funct3    = funct3;
  assign i32.addr      = addr[31:0];
  assign i32.wdata     = wdata[31:0];
  assign i32.mem_ack   = mem_ack & !use64;
  assign i32.mem_rdata = mem_rdata[31:0];

  assign i64.req_valid = req_valid & use64;
  assign i64.req_write = req_write;
  assign i64.funct3    = funct3;
  assign i64.addr      = addr;
  assign i64.wdata     = wdata;
  assign i64.mem_ack   = mem_ack & use64;
  assign i64.mem_rdata = mem_rdata;

  logic        o_fault, o_stall, o_done, o_req, o_we;
  logic [7:0]  o_be;
  logic [63:0] o_maddr, o_mwd, o_rdata;

  assign o_fault = use64 ? i64.fault : i32.fault;
  assign o_stall = use64 ? i64.stall : i32.stall;
  assign o_done  = use64 ? i64.done : i32.done;
  assign o_req   = use64 ? i64.mem_req : i32.mem_req;
  assign o_we    = use64 ? i64.mem_we : i32.mem_we;
  assign o_be    = use64 ? i64.mem_be : {4'b0, i32.mem_be};
  assign o_maddr = use64 ? i64.mem_addr : {32'b0, i32.mem_addr};
  assign o_mwd   = use64 ? i64.mem_wdata : {32'b0, i32.mem_wdata};
  assign o_rdata = use64 ? i64.rdata : {32'b0, i32.rdata};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3, input bit x64);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      3'd3:       return x64 ? 8 : 0;
      3'd6:       return x64 ? 4 : 0;
      default:    return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access; caller is at posedge+1 with the DUT in IDLE.
  task automatic do_op(input bit w, input logic [2:0] f3,
                       input logic [63:0] a_in, input logic [63:0] wd_in,
                       input int dly, input logic [63:0] mrd);
    int          xl, nb, sz, off, keep;
    bit          ef;
    logic [63:0] xm, a, wd, ebe, ea, lm, ewd, v, km, rd;
    xl = use64 ? 64 : 32;
    nb = xl / 8;
    xm = use64 ? '1 : 64'h0000_0000_FFFF_FFFF;
    a  = a_in & xm;
    wd = wd_in & xm;
    sz = size_of(f3, use64);
    ef = (sz == 0) || ((a % 64'(sz)) != 0);
    req_valid = 1'b1;
    req_write = w;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #4;
    chk("fault", o_fault, ef);
    chk("stall_acc", o_stall, !ef);
    chk("req_acc", o_req, 0);
    tick();
    req_valid = 1'b0;
    funct3    = 3'($urandom);
    addr      = {$urandom, $urandom};
    wdata     = {$urandom, $urandom};
    if (ef) begin
      #4;
      chk("req_flt", o_req, 0);
      chk("stall_flt", o_stall, 0);
      tick();
      return;
    end
    off = int'(a % 64'(nb));
    ebe = ((64'd1 << sz) - 64'd1) << off;
    ea  = a - 64'(off);
    lm  = '0;
    for (int i = 0; i < 8; i++)
      if (ebe[i]) lm[8*i +: 8] = 8'hFF;
    ewd = (wd << (8 * off)) & lm & xm;
    for (int c = 1; c <= dly; c++) begin
      if (c == dly) begin
        mem_ack   = 1'b1;
        mem_rdata = mrd;
      end
      #4;
      chk("req_busy", o_req, 1);
      chk("we_busy", o_we, w);
      chk("be_busy", o_be, ebe);
      chk("maddr_busy", o_maddr, ea);
      chk("wdata_busy", o_mwd & lm, ewd);
      chk("stall_busy", o_stall, 1);
      chk("done_busy", o_done, 0);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
    end
    if (!w) begin
      keep = sz * 8;
      v    = (mrd & xm) >> (8 * off);
      km   = (keep == 64) ? '1 : ((64'd1 << keep) - 64'd1);
      v    = v & km;
      if (!f3[2] && keep < xl && v[keep-1]) v = v | (xm & ~km);
      if (use64) exp_rd64 = v;
      else exp_rd32 = v;
    end
    rd = use64 ? exp_rd64 : exp_rd32;
    req_valid = 1'b1;
    req_write = 1'b0;
    funct3    = 3'd0;
    mem_ack   = 1'b1;
    #4;
    chk("done", o_done, 1);
    chk("stall_done", o_stall, 0);
    chk("fault_done", o_fault, 0);
    chk("req_done", o_req, 0);
    chk("rdata", o_rdata, rd);
    tick();
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    #4;
    chk("done_idle", o_done, 0);
    chk("req_idle", o_req, 0);
    tick();
  endtask

  initial begin
    logic [2:0]  f3;
    logic [63:0] a;
    int          sz;

    tick();
    tick();
    #4;
    chk("rst_req32", i32.mem_req, 0);
    chk("rst_be32", i32.mem_be, 0);
    chk("rst_rd32", i32.rdata, 0);
    chk("rst_done32", i32.done, 0);
    chk("rst_req64", i64.mem_req, 0);
    chk("rst_addr64", i64.mem_addr, 0);
    chk("rst_rd64", i64.rdata, 0);
    chk("rst_stall64", i64.stall, 0);
    tick();
    reset = 1'b0;
    tick();

    use64 = 1'b0;
    do_op(1'b1, 3'd0, 64'h103, 64'hAB, 1, 64'h0);
    do_op(1'b0, 3'd1, 64'h102, 64'h0, 1, 64'h8001_1234);
    do_op(1'b0, 3'd5, 64'h102, 64'h0, 1, 64'h8001_1234);
    do_op(1'b0, 3'd2, 64'h102, 64'h0, 1, 64'h0);
    do_op(1'b0, 3'd3, 64'h100, 64'h0, 1, 64'h0);
    do_op(1'b0, 3'd7, 64'h100, 64'h0, 1, 64'h0);
    do_op(1'b1, 3'd2, 64'h200, 64'hCAFE_F00D, 4, 64'h0);

    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom);
      a  = {$urandom, $urandom};
      sz = size_of(f3, 1'b0);
      if (sz != 0 && $urandom_range(3) != 0) a = a & ~64'(sz - 1);
      do_op(1'($urandom), f3, a, {$urandom, $urandom},
            $urandom_range(4, 1), {$urandom, $urandom});
      if ($urandom_range(3) == 0) begin
        mem_ack = 1'b1;
        #4;
        chk("ack_idle_req", o_req, 0);
        tick();
        mem_ack = 1'b0;
        #4;
        chk("ack_idle_done", o_done, 0);
        tick();
      end
    end

    do_op(1'b0, 3'd2, 64'h300, 64'h0, 1, 64'h1357_9BDF);
    req_valid = 1'b1;
    req_write = 1'b0;
    funct3    = 3'd2;
    addr      = 64'h200;
    tick();
    req_valid = 1'b0;
    tick();
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 64'hDEAD_BEEF;
    #4;
    chk("rst_busy_req", o_req, 1);
    tick();
    reset   = 1'b0;
    mem_ack = 1'b0;
    exp_rd32 = '0;
    #4;
    chk("rst_req", o_req, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rdata", o_rdata, 0);
    tick();
    #4;
    chk("rst_nodone", o_done, 0);
    tick();

    use64 = 1'b1;
    do_op(1'b0, 3'd3, 64'h18, 64'h0, 1, 64'h8000_0000_0000_0001);
    do_op(1'b0, 3'd6, 64'h1C, 64'h0, 1, 64'hFFFF_FFFF_0000_0000);
    do_op(1'b0, 3'd7, 64'h20, 64'h0, 1, 64'h0);
    do_op(1'b1, 3'd3, 64'h1C, 64'h0, 1, 64'h0);
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom);
      a  = {$urandom, $urandom};
      sz = size_of(f3, 1'b1);
      if (sz != 0 && $urandom_range(3) != 0) a = a & ~64'(sz - 1);
      do_op(1'($urandom), f3, a, {$urandom, $urandom},
            $urandom_range(3, 1), {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving data/address width; the legal values are 32 and 64.
REQ-002 The block SHALL have derived parameter NB = XLEN/8, giving the byte-lane count.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is a synchronous active-high reset.
REQ-005 Port req_valid, input, 1, is high while the M-stage holds a load or store.
REQ-006 Port req_write, input, 1, selects the operation: 1 = store, 0 = load.
REQ-007 Port funct3, input, 3, is the RISC-V width/sign code of the access.
REQ-008 Port addr, input, XLEN, is the byte address of the access.
REQ-009 Port wdata, input, XLEN, is the store data, right-aligned.
REQ-010 Port stall, output, 1, holds the F/D/E/M pipeline registers when high.
REQ-011 Port done, output, 1, pulses for one cycle when an access completes.
REQ-012 Port rdata, output, XLEN, is the extended load result; it is valid while done is high.
REQ-013 Port fault, output, 1, flags a misaligned access or an illegal funct3.
REQ-014 Port mem_req, output, 1, requests a memory access.
REQ-015 Port mem_we, output, 1, is the memory write enable.
REQ-016 Port mem_be, output, NB, carries the byte-lane strobes.
REQ-017 Port mem_addr, output, XLEN, is the NB-aligned word address.
REQ-018 Port mem_wdata, output, XLEN, is the lane-positioned store data.
REQ-019 Port mem_ack, input, 1, is the memory's one-cycle completion pulse.
REQ-020 Port mem_rdata, input, XLEN, is the full-word read data; it is valid with mem_ack.

Function
REQ-021 The FSM SHALL have three states, IDLE, BUSY and DONE, with these transitions:
- IDLE -> BUSY on req_valid & !fault.
- BUSY -> DONE on mem_ack.
- DONE -> IDLE unconditionally.
REQ-022 Width SHALL follow funct3:
- 000/100: byte; 001/101: half; 010: word.
- 110 (wu) and 011 (d): double/word-unsigned, legal only when XLEN=64.
- 111, and 011/110 when XLEN=32: illegal.
REQ-023 fault SHALL be combinational and asserted only in IDLE with req_valid high, when addr is not a multiple of the access size or funct3 is illegal.
REQ-024 A faulting access SHALL issue no mem_req, leave stall low, and leave the state in IDLE.
REQ-025 On the IDLE->BUSY edge the block SHALL latch addr[log2(NB)-1:0], funct3, req_write and wdata; later input changes SHALL NOT affect the access in flight.
REQ-026 mem_req, mem_we, mem_be, mem_addr and mem_wdata SHALL be registered and held constant for the whole of BUSY; mem_req SHALL equal (state==BUSY).
REQ-027 mem_addr SHALL equal the latched addr with bits [log2(NB)-1:0] cleared.
REQ-028 mem_be SHALL equal the width mask (1, 3, F or FF) shifted left by the byte offset, for both loads and stores.
REQ-029 mem_wdata SHALL equal wdata shifted left by 8*offset; bits outside the strobed lanes are don't-care.
REQ-030 stall SHALL equal (state==IDLE & req_valid & !fault) | (state==BUSY), and SHALL be low in DONE.
REQ-031 On the mem_ack cycle in BUSY, the block SHALL register rdata as mem_rdata >> 8*offset, sign-extended (000/001/010) or zero-extended (100/101/110) from the access width.
REQ-032 rdata SHALL hold that value until the next load completes; stores SHALL NOT change rdata.
REQ-033 done SHALL equal (state==DONE).
REQ-034 Minimum latency: accept at cycle t, mem_req at t+1, done at t+2 when mem_ack arrives at t+1.
REQ-035 Each additional cycle without mem_ack SHALL add exactly one stall cycle.
REQ-036 mem_ack in IDLE or DONE SHALL be ignored.
REQ-037 A req_valid seen in DONE SHALL NOT start an access; the pipeline advances in DONE, so the next op is sampled in IDLE.

Reset
REQ-038 reset SHALL force state IDLE and clear mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata, done and stall-contributing state to 0 on the next edge.
REQ-039 A reset in BUSY SHALL drop mem_req on that edge and SHALL discard a mem_ack arriving in the same cycle.

Verification (XLEN=32 unless stated)
REQ-040 sb, addr 0x103, wdata 0x000000AB, mem_ack at t+1 -> expect mem_addr 0x100, mem_be 1000b, mem_wdata[31:24] 0xAB, mem_we 1, stall high at t and t+1, done at t+2.
REQ-041 lh, addr 0x102, mem_rdata 0x8001_1234 -> expect rdata 0xFFFF8001; lhu at the same address -> expect rdata 0x00008001.
REQ-042 lw, addr 0x102 -> expect fault 1 in the same cycle, stall 0, and no mem_req ever; funct3 011 -> expect fault 1.
REQ-043 sw with mem_ack delayed to the 4th BUSY cycle -> expect stall high for 5 cycles, mem_req and outputs stable for 4 cycles, and done on the 6th cycle.
REQ-044 reset asserted in the 2nd BUSY cycle, with mem_ack in the same cycle -> expect mem_req 0, state IDLE, rdata 0, and no done pulse.
REQ-045 XLEN=64: ld, addr 0x18, mem_rdata 0x8000_0000_0000_0001 -> expect mem_be 0xFF and rdata equal to mem_rdata; lwu, addr 0x1C, mem_rdata[63:32] 0xFFFFFFFF -> expect rdata 0x00000000_FFFFFFFF.
